// File: rtl/data_mem_unit.sv
// Data-side memory stage: word RAM with byte/half lane steering, sign/zero
// extended loads, a sticky misalignment trap and a small MMIO window.
module data_mem_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] wr_mem_data,
  input  logic [2:0]  rw_type,
  output logic [31:0] rd_mem_data,
  output logic [15:0] led,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [15:0]       led_q, led_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic [31:0]       store_cnt_q, store_cnt_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              type_valid, aligned, access_ok, misalign, is_mmio;
  logic              ram_we, led_we;
  logic [1:0]        size;
  logic [3:0]        byte_en;
  logic [31:0]       wr_lanes, raw_word, byte_shift, ext_data;
  logic [15:0]       half_sel;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       mmio_off;

  always_comb begin
    size     = rw_type[1:0];
    word_idx = ram_addr[ADDR_W+1:2];
    mmio_off = ram_addr[15:0];
    is_mmio  = (ram_addr[31:16] == MMIO_BASE[31:16]);

    case (rw_type)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: type_valid = 1'b1;
      default:                                type_valid = 1'b0;
    endcase

    case (size)
      2'b01:   aligned = ~ram_addr[0];
      2'b10:   aligned = (ram_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    access_ok = type_valid & aligned;
    misalign  = (rd_en | wr_en) & type_valid & ~aligned;

    // Store data is replicated across lanes so each enabled lane sees the right byte.
    case (size)
      2'b00: begin
        byte_en  = 4'b0001 << ram_addr[1:0];
        wr_lanes = {4{wr_mem_data[7:0]}};
      end
      2'b01: begin
        byte_en  = ram_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_mem_data[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = wr_mem_data;
      end
    endcase

    ram_we = wr_en & access_ok & ~is_mmio;
    led_we = wr_en & access_ok & is_mmio & (mmio_off[15:2] == 14'd0);
  end

  // Load path: pick the addressed word, then the lane, then extend.
  always_comb begin
    raw_word = 32'd0;
    if (is_mmio) begin
      case (mmio_off[15:2])
        14'd0:   raw_word = {16'd0, led_q};
        14'd1:   raw_word = cycle_cnt_q;
        14'd2:   raw_word = store_cnt_q;
        default: raw_word = 32'd0;
      endcase
    end else begin
      raw_word = mem_q[word_idx];
    end

    byte_shift = raw_word >> {ram_addr[1:0], 3'b000};
    half_sel   = ram_addr[1] ? raw_word[31:16] : raw_word[15:0];

    case (size)
      2'b00:   ext_data = rw_type[2] ? {24'd0, byte_shift[7:0]}
                                     : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   ext_data = rw_type[2] ? {16'd0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
      default: ext_data = raw_word;
    endcase

    rd_mem_data = (rd_en & access_ok) ? ext_data : 32'd0;
  end

  // Only the two low lanes exist in the LED register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_led_lane
      assign led_d[gi*8 +: 8] = (led_we & byte_en[gi]) ? wr_lanes[gi*8 +: 8]
                                                       : led_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    store_cnt_d = store_cnt_q + {31'd0, ram_we};
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    if (misalign && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = ram_addr;
    end
  end

  // RAM has no reset: a store in the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[word_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      led_q       <= 16'd0;
      cycle_cnt_q <= 32'd0;
      store_cnt_q <= 32'd0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'd0;
    end else begin
      led_q       <= led_d;
      cycle_cnt_q <= cycle_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign led          = led_q;
  assign misalign_err = err_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: byte-addressed reference model, directed
// scenarios followed by randomized traffic.
module tb_data_mem_unit;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam logic [2:0]  T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] ram_addr = 32'd0, wr_mem_data = 32'd0;
  logic [2:0]  rw_type = 3'b010;
  logic [31:0] rd_mem_data, err_addr;
  logic [15:0] led;
  logic        misalign_err;

  always #5 clk = ~clk;

  data_mem_unit #(.ADDR_W(8), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .ram_addr(ram_addr), .wr_mem_data(wr_mem_data), .rw_type(rw_type),
    .rd_mem_data(rd_mem_data), .led(led), .misalign_err(misalign_err),
    .err_addr(err_addr)
  );

  // Reference model: memory as 1024 individual bytes, registers as plain values.
  logic [7:0]  m_ram [1024];
  logic [15:0] m_led;
  logic [31:0] m_cyc, m_stores, m_err_addr;
  logic        m_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] addr;
    logic [2:0]  t;
  } exp_t;
  exp_t sb_q[$];

  function automatic int nbytes(input logic [2:0] t);
    return (t[1:0] == 2'b00) ? 1 : ((t[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit tvalid(input logic [2:0] t);
    return (t == T_B) || (t == T_H) || (t == T_W) || (t == T_BU) || (t == T_HU);
  endfunction

  function automatic bit is_aligned(input logic [31:0] a, input logic [2:0] t);
    return (a & 32'(nbytes(t) - 1)) == 32'd0;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == MB[31:16];
  endfunction

  function automatic logic [31:0] mmio_word(input logic [15:0] off);
    case (off & 16'hFFFC)
      16'h0000: return {16'h0, m_led};
      16'h0004: return m_cyc;
      16'h0008: return m_stores;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    if (is_mmio(a)) begin
      w = mmio_word(a[15:0]);
      w = w >> (8 * int'(a[1:0]));
      return w[7:0];
    end
    return m_ram[a[9:0]];
  endfunction

  function automatic logic [31:0] model_load(input bit re, input logic [31:0] a, input logic [2:0] t);
    logic [31:0] v;
    int n;
    if (!re || !tvalid(t) || !is_aligned(a, t)) return 32'd0;
    n = nbytes(t);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(get_byte(a + 32'(k))) << (8 * k));
    if (!t[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!t[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_edge(input bit we, input bit re, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] t, input bit rst);
    bit ok;
    int n;
    int lane;
    logic [9:0] ba;
    ok = tvalid(t) && is_aligned(a, t);
    n  = nbytes(t);
    if (we && ok && !is_mmio(a)) begin
      for (int k = 0; k < n; k++) begin
        ba = a[9:0] + 10'(k);
        m_ram[ba] = d[8*k +: 8];
      end
      if (!rst) m_stores = m_stores + 1;
    end else if (we && ok && !rst && (a[15:0] & 16'hFFFC) == 16'h0) begin
      for (int k = 0; k < n; k++) begin
        lane = int'(a[1:0]) + k;
        if (lane < 2) m_led[8*lane +: 8] = d[8*k +: 8];
      end
    end
    if (rst) begin
      m_led = 16'h0; m_cyc = 32'd0; m_stores = 32'd0; m_err = 1'b0; m_err_addr = 32'd0;
    end else begin
      m_cyc = m_cyc + 1;
      if ((we || re) && tvalid(t) && !is_aligned(a, t) && !m_err) begin
        m_err = 1'b1;
        m_err_addr = a;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // One bus cycle; called just after a rising edge and returns just after the next.
  task automatic cyc(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] t, input bit fixed = 1'b0, input logic [31:0] fexp = 32'd0);
    exp_t e;
    wr_en = we; rd_en = re; ram_addr = a; wr_mem_data = d; rw_type = t;
    e.exp  = fixed ? fexp : model_load(re, a, t);
    e.addr = a;
    e.t    = t;
    sb_q.push_back(e);
    @(posedge clk);
    model_edge(we, re, a, d, t, rst_n);
    #1;
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    chk("err_addr", err_addr, m_err_addr);
  endtask

  task automatic do_reset(input logic [31:0] a, input logic [31:0] d);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, a, d, T_W);
    rst_n = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      $display("txn addr=%h type=%0d rd_en=%0b wr_en=%0b rd_data=%h", e.addr, e.t, rd_en, wr_en, rd_mem_data);
      if (rd_mem_data !== e.exp) begin
        failures++;
        $display("FAIL rd_mem_data addr=%h type=%0d got=%h expected=%h", e.addr, e.t, rd_mem_data, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] a;
    m_led = 16'h0; m_cyc = 32'd0; m_stores = 32'd0; m_err = 1'b0; m_err_addr = 32'd0;
    for (int i = 0; i < 1024; i++) m_ram[i] = 8'h00;
    @(posedge clk); #1;

    do_reset(32'h0, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_err", {31'd0, misalign_err}, 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);

    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 32'(i * 4), $urandom, T_W);
    do_reset(32'h100, 32'h5555_AAAA);

    // Partial-lane merge and store counter from reset
    cyc(1'b1, 1'b0, 32'h20, 32'h1122_3344, T_W);
    cyc(1'b1, 1'b0, 32'h21, 32'h0000_00AA, T_B);
    cyc(1'b1, 1'b0, 32'h22, 32'h0000_BEEF, T_H);
    cyc(1'b0, 1'b1, 32'h20, 32'h0, T_W, 1'b1, 32'hBEEF_AA44);
    cyc(1'b0, 1'b1, MB + 32'h8, 32'h0, T_W, 1'b1, 32'd3);

    // Extension of every load flavour
    cyc(1'b1, 1'b0, 32'h10, 32'h8000_00FF, T_W);
    cyc(1'b0, 1'b1, 32'h10, 32'h0, T_W,  1'b1, 32'h8000_00FF);
    cyc(1'b0, 1'b1, 32'h10, 32'h0, T_B,  1'b1, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 32'h10, 32'h0, T_BU, 1'b1, 32'h0000_00FF);
    cyc(1'b0, 1'b1, 32'h12, 32'h0, T_H,  1'b1, 32'hFFFF_8000);
    cyc(1'b0, 1'b1, 32'h12, 32'h0, T_HU, 1'b1, 32'h0000_8000);

    // Misalignment: first fault latched, later ones ignored, store suppressed
    cyc(1'b0, 1'b1, 32'h21, 32'h0, T_W, 1'b1, 32'h0);
    chk("misalign_set", {31'd0, misalign_err}, 32'd1);
    chk("err_addr_first", err_addr, 32'h21);
    cyc(1'b1, 1'b0, 32'h33, 32'h0000_FFFF, T_H);
    chk("err_addr_kept", err_addr, 32'h21);
    cyc(1'b0, 1'b1, 32'h30, 32'h0, T_W);
    cyc(1'b0, 1'b1, MB + 32'h8, 32'h0, T_W, 1'b1, 32'd4);

    // LED register lanes
    cyc(1'b1, 1'b0, MB, 32'h0000_1234, T_H);
    chk("led_sh", {16'h0, led}, 32'h1234);
    cyc(1'b1, 1'b0, MB + 32'h1, 32'h0000_0056, T_B);
    chk("led_sb", {16'h0, led}, 32'h5634);
    cyc(1'b0, 1'b1, MB, 32'h0, T_W, 1'b1, 32'h0000_5634);
    cyc(1'b1, 1'b0, MB + 32'h4, 32'h0, T_W);
    cyc(1'b0, 1'b1, MB + 32'h4, 32'h0, T_W);

    // Reset mid-run with a store in the reset cycle
    do_reset(32'h40, 32'hCAFE_F00D);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_err", {31'd0, misalign_err}, 32'h0);
    cyc(1'b0, 1'b1, MB + 32'h4, 32'h0, T_W, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, T_W, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, MB + 32'h4, 32'h0, T_W, 1'b1, 32'd5);
    cyc(1'b0, 1'b1, 32'h40, 32'h0, T_W, 1'b1, 32'hCAFE_F00D);
    cyc(1'b0, 1'b1, MB + 32'h8, 32'h0, T_W, 1'b1, 32'd0);

    // Invalid access types do nothing
    cyc(1'b1, 1'b1, 32'h40, 32'h0, 3'b011, 1'b1, 32'h0);
    cyc(1'b1, 1'b1, 32'h41, 32'h0, 3'b110, 1'b1, 32'h0);
    chk("invalid_no_err", {31'd0, misalign_err}, 32'h0);
    cyc(1'b0, 1'b1, 32'h40, 32'h0, T_W, 1'b1, 32'hCAFE_F00D);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset($urandom & 32'h0000_FFFC, $urandom);
      end else begin
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a = MB | (a & 32'hF);
        else if (a[31:16] == MB[31:16]) a[16] = 1'b0;
        cyc(1'($urandom), 1'($urandom), a, $urandom, 3'($urandom_range(0, 7)));
      end
    end

    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-side memory stage directly downstream of the single-cycle RISC-V core.
- Consumes the core's ram_addr, wr_mem_data, wr_en, rd_en and rw_type, and returns rd_mem_data in the same cycle.
- Contains the data RAM, byte/halfword lane steering with load sign/zero extension, a misaligned-access trap flag, and a small MMIO window: LED register, cycle counter and store counter.

Parameters:
ADDR_W, 8, word-address bits of the data RAM (2^ADDR_W 32-bit words; default 1 KiB)
MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window (64 KiB window, offset = ram_addr[15:0])

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, ACTIVE-HIGH (1 = reset) despite the name
wr_en  in  1  store request this cycle
rd_en  in  1  load request this cycle
ram_addr  in  32  byte address (core ALU result)
wr_mem_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rw_type  in  3  access type, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd_mem_data  out  32  load data, extended, combinational
led  out  16  MMIO LED register
misalign_err  out  1  sticky misaligned-access flag
err_addr  out  32  byte address of first misaligned access

Behaviour:
- Reset (rst_n=1 at clk edge): led=0, cycle_cnt=0, store_cnt=0, misalign_err=0, err_addr=0. RAM contents are not reset.
- Region decode: MMIO if ram_addr[31:16]==MMIO_BASE[31:16], else RAM. RAM word index = ram_addr[ADDR_W+1:2]; higher address bits are ignored (aliasing).
- Valid rw_type: 000, 001, 010, 100, 101. Any other value means no access: no write, rd_mem_data=0, no error.
- Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00. B/BU are always aligned.
- Loads, zero cycle latency:
  - rd_mem_data is combinational from the current inputs and array contents.
  - Lane selected by addr[1:0] for bytes, addr[1] for halves.
  - B/H sign-extend; BU/HU zero-extend.
  - rd_en=0, invalid type, or misaligned access gives 0.
- Stores, committed at the rising edge:
  - Only when wr_en=1, rw_type valid and aligned.
  - Byte enables: B = one lane per addr[1:0]; H = lanes {1,0} or {3,2} per addr[1]; W = all four lanes. Data is replicated into the selected lanes; other lanes are unchanged.
- rd_en and wr_en both high: the store commits at the edge; rd_mem_data in that cycle shows pre-store contents.
- Misaligned access (rd_en or wr_en with a valid type):
  - Store is suppressed; load returns 0.
  - If misalign_err=0: set misalign_err=1 and latch err_addr=ram_addr at the edge.
  - Later faults do not change err_addr. Only reset clears the flag.
- MMIO offsets (ram_addr[15:0]):
  - 0x0000 LED: read returns {16'b0, led}. Stores update the led lanes selected by the byte enables (lanes 0-1 only; lanes 2-3 ignored).
  - 0x0004 cycle_cnt: read-only, free-running +1 every cycle out of reset, wraps 32'hFFFFFFFF to 0. A read returns the pre-increment value for that cycle.
  - 0x0008 store_cnt: read-only. +1 on each committed RAM store (MMIO stores are not counted). Wraps.
  - Other offsets: read 0, writes ignored. Writes to 0x4/0x8 ignored.
  - Alignment and extension rules apply identically in MMIO.
- MMIO stores never touch the RAM. RAM stores never touch MMIO state.
- Reset asserted mid-operation: a store presented in the reset cycle IS written to RAM (RAM has no reset). All registers take their reset values and store_cnt stays 0.

Test Plan:
- SW 0x8000_00FF to addr 0x10, then LW 0x10 -> 0x8000_00FF; LB 0x10 -> 0xFFFF_FFFF; LBU 0x10 -> 0x0000_00FF; LH 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000.
- SW 0x1122_3344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22 -> LW 0x20 = 0xBEEF_AA44; store_cnt read at MMIO_BASE+8 = 3.
- LW at 0x21 then SH at 0x33 -> rd_mem_data=0, misalign_err=1, err_addr=0x21; word at 0x30 unchanged; store_cnt unchanged.
- SH 0x1234 to MMIO_BASE -> led=0x1234; SB 0x56 to MMIO_BASE+1 -> led=0x5634; LW MMIO_BASE -> 0x0000_5634; SW to MMIO_BASE+4 leaves the counter running.
- Release reset, read cycle_cnt on two loads 5 cycles apart -> difference = 5; hold rst_n=1 one cycle mid-run -> led=0, misalign_err=0, cycle_cnt restarts from 0.
- rw_type=011 with wr_en=1, rd_en=1 @0x40 -> no RAM change, rd_mem_data=0, misalign_err unchanged.
